// File: rtl/ref_burst_sched.sv
// Credit-limited read-burst scheduler: splits a block job into ID-tagged bursts and passes the returned data through.
// Define REF_BURST_SPLIT_4K_EN to also split bursts at 4 KiB address boundaries.
module ref_burst_sched #(
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned MAX_CREDIT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_in,
    input  logic [31:0]  base_addr_in,
    input  logic [23:0]  num_blocks_in,
    output logic         busy_out,
    output logic         done_out,
    output logic [5:0]   rd_id_out,
    output logic [31:0]  rd_addr_out,
    output logic [7:0]   rd_len_out,
    output logic         rd_info_valid_out,
    input  logic         rd_info_rdy_in,
    input  logic [255:0] rd_data_in,
    input  logic         rd_data_valid_in,
    output logic         rd_data_rdy_out,
    output logic [255:0] data_out,
    output logic         data_valid_out,
    input  logic         data_rdy_in
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [31:0] LP_MAX_BURST  = 32'(MAX_BURST);
    localparam logic [31:0] LP_MAX_CREDIT = 32'(MAX_CREDIT);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_addr;
    logic [31:0] r_credit;
    logic [23:0] r_remaining;
    logic [23:0] r_returned;
    logic [23:0] r_num_blocks;
    logic [5:0]  r_id;
    logic [5:0]  r_rd_id;
    logic [31:0] r_rd_addr;
    logic [7:0]  r_rd_len;
    logic        r_valid;
    logic        r_busy;
    logic        r_done;

    logic [31:0] w_limit;
    logic [31:0] w_len;
    logic [31:0] w_hs_len;
    logic        w_hs;
    logic        w_beat;
    logic        w_can_issue;
    logic        w_complete;

`ifdef REF_BURST_SPLIT_4K_EN
    // Bytes left in the 4 KiB page divided by 32; addr[4:0] is always zero.
    assign w_limit = 32'd128 - {25'd0, r_addr[11:5]};
`else
    assign w_limit = 32'd256;
`endif

    always_comb begin
        w_len = LP_MAX_BURST;
        if ({8'd0, r_remaining} < w_len) w_len = {8'd0, r_remaining};
        if (w_limit < w_len)             w_len = w_limit;
    end

    // Bookkeeping on a handshake uses the registered length, not the live one.
    assign w_hs_len    = {24'd0, r_rd_len} + 32'd1;
    assign w_hs        = r_valid & rd_info_rdy_in;
    assign w_beat      = rd_data_valid_in & data_rdy_in & (r_state != IDLE);
    assign w_can_issue = (r_state == ISSUE) && !r_valid && (r_remaining != 24'd0) &&
                         ((r_credit + w_len) <= LP_MAX_CREDIT);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_in && (num_blocks_in != 24'd0)) w_state_next = ISSUE;
            end
            ISSUE: begin
                if (w_hs && ({8'd0, r_remaining} == w_hs_len)) w_state_next = DRAIN;
            end
            DRAIN: begin
                if ((r_returned + 24'(w_beat)) == r_num_blocks) begin
                    w_state_next = IDLE;
                    w_complete   = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_credit     <= '0;
            r_remaining  <= '0;
            r_returned   <= '0;
            r_num_blocks <= '0;
            r_id         <= '0;
            r_rd_id      <= '0;
            r_rd_addr    <= '0;
            r_rd_len     <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (start_in) begin
                    r_addr       <= base_addr_in;
                    r_remaining  <= num_blocks_in;
                    r_num_blocks <= num_blocks_in;
                    r_id         <= '0;
                    r_credit     <= '0;
                    r_returned   <= '0;
                    r_done       <= (num_blocks_in == 24'd0);
                    r_busy       <= (num_blocks_in != 24'd0);
                end
            end else begin
                r_credit <= r_credit + (w_hs ? w_hs_len : '0) - (w_beat ? 32'd1 : '0);
                if (w_beat) r_returned <= r_returned + 24'd1;
                if (w_hs) begin
                    r_valid     <= 1'b0;
                    r_addr      <= r_addr + (w_hs_len << 5);
                    r_remaining <= r_remaining - w_hs_len[23:0];
                    r_id        <= r_id + 6'd1;
                end else if (w_can_issue) begin
                    r_valid   <= 1'b1;
                    r_rd_addr <= r_addr;
                    r_rd_len  <= 8'(w_len - 32'd1);
                    r_rd_id   <= r_id;
                end
                if (w_complete) begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign busy_out          = r_busy;
    assign done_out          = r_done;
    assign rd_id_out         = r_rd_id;
    assign rd_addr_out       = r_rd_addr;
    assign rd_len_out        = r_rd_len;
    assign rd_info_valid_out = r_valid;

    assign data_out          = rd_data_in;
    assign data_valid_out    = rd_data_valid_in;
    assign rd_data_rdy_out   = data_rdy_in;

endmodule

// File: tb/tb_ref_burst_sched.sv
// Randomized bench for ref_burst_sched: a job-level burst list model plus a credit/beat scoreboard.
module tb_ref_burst_sched;

    localparam int unsigned MB = 16;
    localparam int unsigned MC = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_in = 1'b0;
    logic [31:0]  base_addr_in = '0;
    logic [23:0]  num_blocks_in = '0;
    logic         busy_out;
    logic         done_out;
    logic [5:0]   rd_id_out;
    logic [31:0]  rd_addr_out;
    logic [7:0]   rd_len_out;
    logic         rd_info_valid_out;
    logic         rd_info_rdy_in = 1'b0;
    logic [255:0] rd_data_in = '0;
    logic         rd_data_valid_in = 1'b0;
    logic         rd_data_rdy_out;
    logic [255:0] data_out;
    logic         data_valid_out;
    logic         data_rdy_in = 1'b0;

    ref_burst_sched #(.MAX_BURST(MB), .MAX_CREDIT(MC)) u_dut (
        .clk               (clk),
        .rst               (rst),
        .start_in          (start_in),
        .base_addr_in      (base_addr_in),
        .num_blocks_in     (num_blocks_in),
        .busy_out          (busy_out),
        .done_out          (done_out),
        .rd_id_out         (rd_id_out),
        .rd_addr_out       (rd_addr_out),
        .rd_len_out        (rd_len_out),
        .rd_info_valid_out (rd_info_valid_out),
        .rd_info_rdy_in    (rd_info_rdy_in),
        .rd_data_in        (rd_data_in),
        .rd_data_valid_in  (rd_data_valid_in),
        .rd_data_rdy_out   (rd_data_rdy_out),
        .data_out          (data_out),
        .data_valid_out    (data_valid_out),
        .data_rdy_in       (data_rdy_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [5:0]  id;
    } burst_t;

    burst_t exp_q[$];
    burst_t obs_q[$];

    int  n_checks = 0;
    int  n_errors = 0;
    int  pend = 0;
    int  stale = 0;
    int  returned = 0;
    int  job_n = 0;
    int  done_count = 0;
    int  hs_total = 0;
    bit  job_active = 1'b0;
    int  irdy_pct = 100;
    int  dval_pct = 100;
    int  drdy_pct = 100;

    bit          prev_valid = 1'b0;
    bit          prev_rdy = 1'b0;
    bit          prev_hs = 1'b0;
    bit          prev_done = 1'b0;
    logic [31:0] prev_ad = '0;
    logic [7:0]  prev_ln = '0;
    logic [5:0]  prev_id = '0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit coin(input int pct);
        return int'($urandom_range(99, 0)) < pct;
    endfunction

    // Expected burst sequence for a whole job, straight from the splitting rules.
    task automatic build_exp(input logic [31:0] base, input int n);
        logic [31:0] a;
        int rem;
        int id;
        int lim;
        int len;
        burst_t b;
        a = base;
        rem = n;
        id = 0;
        while (rem > 0) begin
`ifdef REF_BURST_SPLIT_4K_EN
            lim = (4096 - int'(a % 32'd4096)) / 32;
`else
            lim = 256;
`endif
            len = int'(MB);
            if (rem < len) len = rem;
            if (lim < len) len = lim;
            b.addr = a;
            b.len  = 8'(len - 1);
            b.id   = 6'(id % 64);
            exp_q.push_back(b);
            a   = a + 32'(32 * len);
            rem = rem - len;
            id++;
        end
    endtask

    task automatic clear_prev();
        prev_valid = 1'b0;
        prev_rdy   = 1'b0;
        prev_hs    = 1'b0;
        prev_done  = 1'b0;
    endtask

    // One clock: observe outputs, drive random inputs, score the edge's events, advance.
    task automatic cycle();
        logic        v;
        logic        dn;
        logic        bz;
        logic [31:0] ad;
        logic [7:0]  ln;
        logic [5:0]  id;
        bit          hs;
        bit          beat;
        burst_t      e;
        burst_t      o;
        v  = rd_info_valid_out;
        dn = done_out;
        bz = busy_out;
        ad = rd_addr_out;
        ln = rd_len_out;
        id = rd_id_out;

        if (prev_done) check("done_width", 256'(dn), 256'(0));
        if (prev_valid && !prev_rdy)
            check("hold_stable", 256'({v, ad, ln, id}), 256'({1'b1, prev_ad, prev_ln, prev_id}));
        if (prev_hs) check("valid_gap", 256'(v), 256'(0));
        if (dn) begin
            done_count++;
            check("done_busy", 256'(bz), 256'(0));
            check("done_returned", 256'(returned), 256'(job_n));
            check("done_bursts_left", 256'(exp_q.size()), 256'(0));
            job_active = 1'b0;
        end else if (job_active) begin
            check("busy_high", 256'(bz), 256'(1));
        end

        rd_info_rdy_in   = coin(irdy_pct);
        rd_data_valid_in = ((pend + stale) > 0) && coin(dval_pct);
        for (int k = 0; k < 8; k++) rd_data_in[k*32 +: 32] = $urandom;
        data_rdy_in = coin(drdy_pct);
        #1;
        check("pass_data", data_out, rd_data_in);
        check("pass_ctl", 256'({rd_data_rdy_out, data_valid_out}), 256'({data_rdy_in, rd_data_valid_in}));

        hs   = v && rd_info_rdy_in;
        beat = rd_data_valid_in && data_rdy_in;
        if (hs) begin
            hs_total++;
            o.addr = ad;
            o.len  = ln;
            o.id   = id;
            obs_q.push_back(o);
            if (exp_q.size() == 0) begin
                check("unexpected_burst", 256'(1), 256'(0));
            end else begin
                e = exp_q.pop_front();
                check("burst_addr", 256'(ad), 256'(e.addr));
                check("burst_len", 256'(ln), 256'(e.len));
                check("burst_id", 256'(id), 256'(e.id));
                check("credit_limit", 256'((pend + int'(ln) + 1) <= int'(MC)), 256'(1));
            end
            pend = pend + int'(ln) + 1;
        end else if (v && exp_q.size() == 0) begin
            check("spurious_valid", 256'(v), 256'(0));
        end
        if (beat) begin
            if (stale > 0) stale--;
            else begin
                pend--;
                returned++;
            end
        end

        prev_valid = v;
        prev_rdy   = rd_info_rdy_in;
        prev_hs    = hs;
        prev_done  = dn;
        prev_ad    = ad;
        prev_ln    = ln;
        prev_id    = id;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [31:0] base, input int n);
        exp_q.delete();
        obs_q.delete();
        build_exp(base, n);
        returned      = 0;
        job_n         = n;
        start_in      = 1'b1;
        base_addr_in  = base;
        num_blocks_in = 24'(n);
        cycle();
        start_in   = 1'b0;
        job_active = (n != 0);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        int d0;
        d0 = done_count;
        cycles = 0;
        while (done_count == d0 && cycles < budget) begin
            cycle();
            cycles++;
        end
        if (done_count == d0) check("done_timeout", 256'(0), 256'(1));
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        start_in         = 1'b0;
        rd_info_rdy_in   = 1'b0;
        rd_data_valid_in = 1'b0;
        data_rdy_in      = 1'b0;
        @(posedge clk);
        #1;
        check("reset_outputs",
              256'({busy_out, done_out, rd_info_valid_out, rd_id_out, rd_addr_out, rd_len_out}),
              256'(0));
        rst = 1'b0;
        clear_prev();
        job_active = 1'b0;
        exp_q.delete();
        stale = stale + pend;
        pend  = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int h0;
        int lim;
        logic [31:0] base;
        logic [31:0] cap_ad;
        logic [7:0]  cap_ln;
        logic [5:0]  cap_id;

        do_reset();

        // Directed 40-block job at 0x1000 with everything ready.
        irdy_pct = 100; dval_pct = 100; drdy_pct = 100;
        start_job(32'h1000, 40);
        wait_done(1000, cyc);
        check("d40_count", 256'(obs_q.size()), 256'(3));
        if (obs_q.size() == 3) begin
            check("d40_b0", 256'({obs_q[0].addr, obs_q[0].len, obs_q[0].id}), 256'({32'h1000, 8'd15, 6'd0}));
            check("d40_b1", 256'({obs_q[1].addr, obs_q[1].len, obs_q[1].id}), 256'({32'h1200, 8'd15, 6'd1}));
            check("d40_b2", 256'({obs_q[2].addr, obs_q[2].len, obs_q[2].id}), 256'({32'h1400, 8'd7, 6'd2}));
        end
        cycle();

        // Zero-length job.
        start_job(32'h8000, 0);
        wait_done(20, cyc);
        check("zero_latency", 256'(cyc), 256'(1));
        check("zero_bursts", 256'(obs_q.size()), 256'(0));
        repeat (3) cycle();

        // Credit stall: no data returns, so only MC blocks may go out.
        h0 = hs_total;
        drdy_pct = 0;
        start_job(32'h0, 100);
        repeat (30) cycle();
        check("stall_bursts", 256'(hs_total - h0), 256'(2));
        check("stall_pend", 256'(pend), 256'(MC));
        check("stall_valid", 256'(rd_info_valid_out), 256'(0));
        drdy_pct = 100;
        wait_done(2000, cyc);
        cycle();

        // Arbiter back-pressure for five cycles.
        irdy_pct = 0;
        start_job(32'h4000, 24);
        lim = 0;
        while (!rd_info_valid_out && lim < 20) begin
            cycle();
            lim++;
        end
        check("bp_valid_seen", 256'(rd_info_valid_out), 256'(1));
        cap_ad = rd_addr_out;
        cap_ln = rd_len_out;
        cap_id = rd_id_out;
        repeat (5) cycle();
        check("bp_hold5", 256'({rd_info_valid_out, rd_addr_out, rd_len_out, rd_id_out}),
              256'({1'b1, cap_ad, cap_ln, cap_id}));
        irdy_pct = 100;
        wait_done(1000, cyc);
        cycle();

        // 4 KiB boundary case.
        start_job(32'h0F80, 16);
        wait_done(1000, cyc);
`ifdef REF_BURST_SPLIT_4K_EN
        check("k4_count", 256'(obs_q.size()), 256'(2));
        if (obs_q.size() == 2) begin
            check("k4_b0", 256'({obs_q[0].addr, obs_q[0].len}), 256'({32'h0F80, 8'd3}));
            check("k4_b1", 256'({obs_q[1].addr, obs_q[1].len}), 256'({32'h1000, 8'd11}));
        end
`else
        check("k4_count", 256'(obs_q.size()), 256'(1));
        if (obs_q.size() == 1)
            check("k4_b0", 256'({obs_q[0].addr, obs_q[0].len}), 256'({32'h0F80, 8'd15}));
`endif
        cycle();

        // Mid-job reset, stale beats in IDLE, then a fresh job from ID 0.
        dval_pct = 0;
        h0 = hs_total;
        start_job(32'h2000, 100);
        lim = 0;
        while (hs_total == h0 && lim < 50) begin
            cycle();
            lim++;
        end
        check("rst_first_burst", 256'(hs_total - h0), 256'(1));
        cycle();
        do_reset();
        dval_pct = 100;
        lim = 0;
        while (stale > 0 && lim < 300) begin
            cycle();
            lim++;
        end
        check("stale_drained", 256'(stale), 256'(0));
        check("stale_idle", 256'({busy_out, rd_info_valid_out}), 256'(0));
        start_job(32'h3000, 20);
        wait_done(1000, cyc);
        if (obs_q.size() > 0) check("post_reset_id", 256'(obs_q[0].id), 256'(0));
        cycle();

        // Address wrap past 0xFFFFFFFF.
        start_job(32'hFFFF_FF00, 40);
        wait_done(1000, cyc);
        cycle();

        // Randomized jobs.
        for (int j = 0; j < 25; j++) begin
            base = $urandom & 32'hFFFF_FFE0;
            if (coin(50)) base[11:0] = 12'hFE0 - 12'(32 * $urandom_range(20, 0));
            irdy_pct = int'($urandom_range(100, 40));
            dval_pct = int'($urandom_range(100, 40));
            drdy_pct = int'($urandom_range(100, 40));
            start_job(base, int'($urandom_range(70, 0)));
            wait_done(3000, cyc);
            repeat (int'($urandom_range(3, 1))) cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ref_burst_sched.md
REF_BURST_SCHED -- requirements
Module: ref_burst_sched

Interface
REQ-001 Parameter MAX_BURST, default 16: maximum 256-bit blocks per read burst, range 1..256.
REQ-002 Parameter MAX_CREDIT, default 64: maximum blocks requested but not yet returned, at least MAX_BURST.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start_in  in  1  one-cycle job start; sampled only in IDLE.
REQ-006 base_addr_in  in  32  job byte address; bits [4:0] are zero.
REQ-007 num_blocks_in  in  24  job length in 256-bit blocks.
REQ-008 busy_out  out  1  high from the cycle after an accepted start until done.
REQ-009 done_out  out  1  one-cycle pulse when the job completes.
REQ-010 rd_id_out  out  6  burst ID.
REQ-011 rd_addr_out  out  32  burst byte address.
REQ-012 rd_len_out  out  8  burst length in blocks, minus one.
REQ-013 rd_info_valid_out  out  1  burst request valid.
REQ-014 rd_info_rdy_in  in  1  burst request accepted by the arbiter port.
REQ-015 rd_data_in  in  256  returned read data.
REQ-016 rd_data_valid_in  in  1  returned data valid.
REQ-017 rd_data_rdy_out  out  1  returned data accepted.
REQ-018 data_out  out  256  data to the consumer.
REQ-019 data_valid_out  out  1  data_out valid.
REQ-020 data_rdy_in  in  1  consumer ready.

Function
REQ-021 The FSM SHALL use three states: IDLE, ISSUE and DRAIN.
- IDLE to ISSUE on start_in with num_blocks_in != 0.
- ISSUE to DRAIN when the final burst handshake occurs.
- DRAIN to IDLE when all blocks have returned; done_out pulses in that same transition cycle.
REQ-022 A start with num_blocks_in == 0 SHALL produce a done_out pulse on the next cycle, with no burst issued and busy_out staying low.
REQ-023 On start, the block SHALL latch next address = base_addr_in, remaining = num_blocks_in, and next ID = 0.
REQ-024 In ISSUE, each burst length L SHALL be min(MAX_BURST, remaining, limit) blocks.
- limit comes from REQ-037.
- rd_len_out = L-1.
- rd_addr_out = next address.
- rd_id_out = next ID.
REQ-025 rd_info_valid_out SHALL assert only when credit + L <= MAX_CREDIT.
- credit = blocks issued minus blocks returned.
REQ-026 rd_info_valid_out is registered; once asserted, it and rd_id/rd_addr/rd_len SHALL hold stable until the cycle in which rd_info_rdy_in is high.
REQ-027 On a burst handshake:
- next address += 32*L.
- remaining -= L.
- next ID increments modulo 64.
- credit += L.
rd_info_valid_out deasserts for at least one cycle before the next burst.
REQ-028 Data path SHALL be combinational pass-through:
- data_out = rd_data_in.
- data_valid_out = rd_data_valid_in.
- rd_data_rdy_out = data_rdy_in.
REQ-029 Each cycle with rd_data_valid_in && data_rdy_in SHALL decrement credit by 1 and increment the returned count.
REQ-030 When a burst handshake and a data beat occur in the same cycle, credit SHALL update by L-1.
REQ-031 The job SHALL complete when the returned count equals the latched num_blocks and remaining == 0.
REQ-032 start_in while busy_out is high SHALL be ignored.
REQ-033 Address arithmetic is 32-bit modulo; wrap past 0xFFFFFFFF SHALL NOT be detected.

Reset
REQ-034 On rst, the following SHALL clear on the next rising edge, including mid-burst:
- state = IDLE.
- busy_out, done_out, rd_info_valid_out = 0.
- rd_id/rd_addr/rd_len = 0.
- credit, remaining, returned count = 0.
REQ-035 Data beats arriving after a mid-job reset SHALL pass through without altering counters while in IDLE.

Configuration
REQ-036 The macro REF_BURST_SPLIT_4K_EN SHALL compile 4 KiB boundary splitting in or out.
REQ-037 With REF_BURST_SPLIT_4K_EN defined:
- limit = (4096 - next_address[11:0]) / 32.
- No burst crosses a 4 KiB boundary.
Without it, limit = 256 and bursts split on MAX_BURST only.

Verification
REQ-038 Job base 0x1000, 40 blocks, rdy always high, defaults -> bursts (0x1000, len 15, ID0), (0x1200, len 15, ID1), (0x1400, len 7, ID2); one done pulse after the 40th beat.
REQ-039 num_blocks 0 -> done_out high exactly one cycle later; rd_info_valid_out never asserts.
REQ-040 MAX_CREDIT 32, data_rdy_in low, 100 blocks -> exactly two 16-block bursts issued, then valid held low until beats return.
REQ-041 rd_info_rdy_in held low for 5 cycles -> valid, addr, len and ID are unchanged across all 5 cycles.
REQ-042 With REF_BURST_SPLIT_4K_EN, base 0x0F80, 16 blocks -> bursts (0x0F80, len 3) and (0x1000, len 11); without it -> single burst len 15.
REQ-043 rst asserted mid-job after 1 burst -> all outputs 0 next cycle; a new job then starts with ID 0.
